// File: rtl/audio_pkg.sv
// Shared audio-path types: fetch scheduler states and the sample delta width.
// No logic; latency and backpressure are not applicable.
package audio_pkg;

    localparam int DELTA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SNAPSHOT,
        SELECT,
        ISSUE,
        WAIT,
        COMMIT
    } sched_state_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lrclk_edge_detect.sv
// Rising-edge detector for an lrclk that is already synchronous to clk.
// Latency: pulse in the cycle lrclk is first seen high; no backpressure.
module lrclk_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic lrclk,
    output logic rise
);

    logic lrclkQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrclkQ <= 1'b0;
        end else begin
            lrclkQ <= lrclk;
        end
    end

    assign rise = lrclk & ~lrclkQ;

endmodule

// File: rtl/channel_fetch_scheduler.sv
// Shares one memory read port among NUM_CHANNELS channels; one word per active channel per lrclk frame.
// Latency: deltas commit together after the frame's fetches; requests hold until i_memAck, one outstanding.
module channel_fetch_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           lrclk,
    input  logic [NUM_CHANNELS-1:0]        i_channelActive,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] i_nextAddress,
    output logic [NUM_CHANNELS*DELTA_W-1:0] o_sampleDelta,
    output logic                           o_memReq,
    output logic [ADDR_W-1:0]              o_memAddress,
    input  logic                           i_memAck,
    input  logic                           i_memValid,
    input  logic [DATA_W-1:0]              i_memData,
    output logic                           o_busy,
    output logic                           o_underrun,
    input  logic                           i_clearUnderrun
);

    localparam int IDX_W = idxWidth(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHANNELS - 1);

    sched_state_t                    state;
    logic [IDX_W-1:0]                index;
    logic [NUM_CHANNELS*ADDR_W-1:0]  snapAddr;
    logic [NUM_CHANNELS-1:0]         snapActive;
    logic [NUM_CHANNELS*DELTA_W-1:0] shadow;
    logic                            pending;
    logic                            rise;
    logic                            abort;
    logic                            unusedDataBits;

    lrclk_edge_detect uEdge (
        .clk   (clk),
        .rst_n (rst_n),
        .lrclk (lrclk),
        .rise  (rise)
    );

    // A frame is cut short by an edge seen now or by one already recorded.
    assign abort          = pending | rise;
    assign unusedDataBits = ^i_memData[DATA_W-1:DELTA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            snapAddr      <= '0;
            snapActive    <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            o_sampleDelta <= '0;
            o_memReq      <= 1'b0;
            o_memAddress  <= '0;
            o_busy        <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            // An edge in COMMIT simply starts the next frame, so it is not an underrun.
            if (rise && state != IDLE && state != COMMIT) begin
                o_underrun <= 1'b1;
                pending    <= 1'b1;
            end else if (i_clearUnderrun) begin
                o_underrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= SETTLE;
                        o_busy <= 1'b1;
                    end
                end
                SETTLE: state <= SNAPSHOT;
                SNAPSHOT: begin
                    snapAddr   <= i_nextAddress;
                    snapActive <= i_channelActive;
                    shadow     <= '0;
                    index      <= '0;
                    state      <= SELECT;
                end
                SELECT: begin
                    if (abort) begin
                        state <= COMMIT;
                    end else if (snapActive[index]) begin
                        state        <= ISSUE;
                        o_memReq     <= 1'b1;
                        o_memAddress <= snapAddr[index*ADDR_W +: ADDR_W];
                    end else if (index == LAST) begin
                        state <= COMMIT;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_memAck) begin
                        o_memReq <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_memValid) begin
                        shadow[index*DELTA_W +: DELTA_W] <= i_memData[DELTA_W-1:0];
                        if (abort || index == LAST) begin
                            state <= COMMIT;
                        end else begin
                            index <= index + 1'b1;
                            state <= SELECT;
                        end
                    end
                end
                COMMIT: begin
                    o_sampleDelta <= shadow;
                    pending       <= 1'b0;
                    if (abort) begin
                        state <= SETTLE;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
